// File: rtl/hpdmc_pkg.sv
// Shared HPDMC definitions: input-delay controller op encodings and FSM state encoding.
package hpdmc_pkg;

  typedef enum logic [1:0] {
    IDELAY_OP_RESET = 2'b00,
    IDELAY_OP_INC   = 2'b01,
    IDELAY_OP_DEC   = 2'b10,
    IDELAY_OP_SET   = 2'b11
  } idelay_op_e;

  // ST_INIT holds the delay bank in reset for one cycle after sys_rst releases.
  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RSTP = 3'd2,
    ST_STEP = 3'd3,
    ST_GAP  = 3'd4,
    ST_FIN  = 3'd5
  } idelay_state_e;

endpackage

// File: rtl/hpdmc_idelay_ctl_if.sv
// CSR-side command interface of the input-delay controller: command handshake, completion and tap readback.
interface hpdmc_idelay_ctl_if #(
  parameter int TAP_W = 6
);
  import hpdmc_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  idelay_op_e       cmd_op;
  logic [TAP_W-1:0] cmd_arg;
  logic             done;
  logic             clamped;
  logic [TAP_W-1:0] tap;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    input  cmd_ready, done, clamped, tap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    output cmd_ready, done, clamped, tap
  );

endinterface

// File: rtl/hpdmc_idelay_ctl.sv
// Turns tap commands into spaced ce/inc/rst pulses for the DQ input-delay bank and tracks the tap.
// Optional HPDMC_IDELAY_LIMIT_EN: clamp INC/DEC at the tap range ends instead of wrapping.
module hpdmc_idelay_ctl
  import hpdmc_pkg::*;
#(
  parameter int GAP_CYCLES = 3,
  parameter int TAP_W      = 6
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  hpdmc_idelay_ctl_if.slave  cmd,
  output logic               idelay_rst,
  output logic               idelay_ce,
  output logic               idelay_inc
);

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
`ifdef HPDMC_IDELAY_LIMIT_EN
  localparam logic [TAP_W-1:0] TAP_MAX  = '1;
`endif

  idelay_state_e    state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             clamp_q, clamp_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic rst_q, rst_d;
  logic ce_q, ce_d;
  logic inc_q, inc_d;
  logic done_q, done_d;
  logic clamped_q, clamped_d;

  logic             accept;
  logic [TAP_W-1:0] acc_count;
  logic             acc_dir;
  logic             acc_clamp;

  assign cmd.cmd_ready = (state_q == ST_IDLE) & ~sys_rst;
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

  // Step count and direction of the incoming command, relative to the current tap.
  always_comb begin
    acc_dir   = 1'b0;
    acc_count = cmd.cmd_arg;
    acc_clamp = 1'b0;
    case (cmd.cmd_op)
      IDELAY_OP_INC: begin
        acc_dir = 1'b1;
`ifdef HPDMC_IDELAY_LIMIT_EN
        if (cmd.cmd_arg > (TAP_MAX - tap_q)) begin
          acc_count = TAP_MAX - tap_q;
          acc_clamp = 1'b1;
        end
`endif
      end
      IDELAY_OP_DEC: begin
        acc_dir = 1'b0;
`ifdef HPDMC_IDELAY_LIMIT_EN
        if (cmd.cmd_arg > tap_q) begin
          acc_count = tap_q;
          acc_clamp = 1'b1;
        end
`endif
      end
      IDELAY_OP_SET: begin
        acc_dir   = cmd.cmd_arg > tap_q;
        acc_count = acc_dir ? (cmd.cmd_arg - tap_q) : (tap_q - cmd.cmd_arg);
      end
      default: acc_count = '0;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    count_d = count_q;
    dir_d   = dir_q;
    clamp_d = clamp_q;
    gap_d   = gap_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          dir_d   = acc_dir;
          count_d = acc_count;
          clamp_d = acc_clamp;
          if (cmd.cmd_op == IDELAY_OP_RESET) state_d = ST_RSTP;
          else if (acc_count != '0)          state_d = ST_STEP;
          else                               state_d = ST_FIN;
        end
      end
      ST_RSTP: begin
        tap_d   = '0;
        state_d = ST_FIN;
      end
      ST_STEP: begin
        tap_d   = dir_q ? (tap_q + 1'b1) : (tap_q - 1'b1);
        count_d = count_q - 1'b1;
        gap_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = (count_q != '0) ? ST_STEP : ST_FIN;
        else             gap_d   = gap_q - 1'b1;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs decoded from the next state so every bank/CSR output leaves a flop.
  always_comb begin
    rst_d     = (state_d == ST_RSTP) | (state_d == ST_INIT);
    ce_d      = (state_d == ST_STEP);
    inc_d     = ce_d & dir_d;
    done_d    = (state_d == ST_FIN);
    clamped_d = done_d & clamp_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_INIT;
      tap_q     <= '0;
      rst_q     <= 1'b1;
      ce_q      <= 1'b0;
      inc_q     <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      rst_q     <= rst_d;
      ce_q      <= ce_d;
      inc_q     <= inc_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
    end
  end

  // Command context is only meaningful while busy, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    count_q <= count_d;
    dir_q   <= dir_d;
    clamp_q <= clamp_d;
    gap_q   <= gap_d;
  end

  assign cmd.tap     = tap_q;
  assign cmd.done    = done_q;
  assign cmd.clamped = clamped_q;
  assign idelay_rst  = rst_q;
  assign idelay_ce   = ce_q;
  assign idelay_inc  = inc_q;

endmodule

// File: tb/tb_hpdmc_idelay_ctl.sv
// Self-checking bench for hpdmc_idelay_ctl: table of directed commands, random commands
// against a transaction-level model, and hand-written reset/abort sequences.
`timescale 1ns/1ps
module tb_hpdmc_idelay_ctl;
  import hpdmc_pkg::*;

  localparam int GAP   = 3;
  localparam int TAP_W = 6;
  localparam int TAPS  = 1 << TAP_W;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic idelay_rst, idelay_ce, idelay_inc;

  hpdmc_idelay_ctl_if #(.TAP_W(TAP_W)) cmd_if ();

  hpdmc_idelay_ctl #(.GAP_CYCLES(GAP), .TAP_W(TAP_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cmd        (cmd_if.slave),
    .idelay_rst (idelay_rst),
    .idelay_ce  (idelay_ce),
    .idelay_inc (idelay_inc)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int m_tap = 0;

  typedef struct {
    int op; int arg; bit hold;
    int pulses; int dir; int tap; int lat; int clamped; int rsts;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: what one command should do to the bank and the tap.
  task automatic model(input int tap, input int op, input int arg,
                       output int pulses, output int dir, output int ntap,
                       output int lat, output int clamped, output int rsts);
    pulses = 0; dir = 0; ntap = tap; clamped = 0; rsts = 0; lat = 1;
    case (op)
      0: begin ntap = 0; rsts = 1; end
      1: begin
        dir = 1; pulses = arg;
`ifdef HPDMC_IDELAY_LIMIT_EN
        if (tap + arg > TAPS - 1) begin pulses = TAPS - 1 - tap; clamped = 1; end
`endif
        ntap = (tap + pulses) % TAPS;
      end
      2: begin
        dir = 0; pulses = arg;
`ifdef HPDMC_IDELAY_LIMIT_EN
        if (arg > tap) begin pulses = tap; clamped = 1; end
`endif
        ntap = (tap - pulses + TAPS) % TAPS;
      end
      default: begin
        dir = (arg > tap) ? 1 : 0;
        pulses = dir ? arg - tap : tap - arg;
        ntap = arg;
      end
    endcase
    lat = (op == 0) ? 2 : 1 + pulses * (1 + GAP);
  endtask

  // Issues one command at a negedge and observes the bank until done (bounded).
  task automatic run_cmd(input int op, input int arg, input bit hold_busy, input int exp_dir,
                         output int pulses, output int bad_dir, output int rsts, output int lat,
                         output int clamped, output int viol, output int ready_after);
    bit prev_ce = 1'b0;
    bit got = 1'b0;
    pulses = 0; bad_dir = 0; rsts = 0; lat = -1; clamped = -1; viol = 0;
    for (int w = 0; w < 8 && !cmd_if.cmd_ready; w++) @(negedge sys_clk);
    chk("ready_before_cmd", int'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = idelay_op_e'(2'(op));
    cmd_if.cmd_arg   = TAP_W'(arg);
    for (int k = 1; k <= 400 && !got; k++) begin
      @(negedge sys_clk);
      if (hold_busy) begin
        cmd_if.cmd_op  = IDELAY_OP_INC;
        cmd_if.cmd_arg = TAP_W'(7);
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
      if (idelay_ce) begin
        pulses++;
        if (int'(idelay_inc) != exp_dir) bad_dir++;
        if (prev_ce || idelay_rst) viol++;
      end
      if (idelay_rst) rsts++;
      if (cmd_if.cmd_ready) viol++;
      prev_ce = idelay_ce;
      if (cmd_if.done) begin
        got = 1'b1;
        lat = k;
        clamped = int'(cmd_if.clamped);
        cmd_if.cmd_valid = 1'b0;
      end
    end
    @(negedge sys_clk);
    ready_after = int'(cmd_if.cmd_ready);
    if (cmd_if.done || idelay_ce || idelay_rst) viol++;
  endtask

  task automatic apply_model(input int op, input int arg, input string tag);
    int ep, ed, et, el, ec, er;
    int p, bd, r, l, c, v, ra;
    model(m_tap, op, arg, ep, ed, et, el, ec, er);
    run_cmd(op, arg, 1'b0, ed, p, bd, r, l, c, v, ra);
    chk({tag, "_pulses"}, p, ep);
    chk({tag, "_inc_dir"}, bd, 0);
    chk({tag, "_rst_pulses"}, r, er);
    chk({tag, "_done_latency"}, l, el);
    chk({tag, "_clamped"}, c, ec);
    chk({tag, "_protocol"}, v, 0);
    chk({tag, "_tap"}, int'(cmd_if.tap), et);
    m_tap = et;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, bd, r, l, c, v, ra, dn;

    tbl[0] = '{1,  3, 1'b0,  3, 1,  3,  13, 0, 0};
    tbl[1] = '{3,  5, 1'b0,  2, 1,  5,   9, 0, 0};
    tbl[2] = '{3,  2, 1'b0,  3, 0,  2,  13, 0, 0};
    tbl[3] = '{3,  2, 1'b0,  0, 0,  2,   1, 0, 0};
    tbl[4] = '{3, 62, 1'b0, 60, 1, 62, 241, 0, 0};
`ifdef HPDMC_IDELAY_LIMIT_EN
    tbl[5] = '{1,  4, 1'b0,  1, 1, 63,   5, 1, 0};
    tbl[6] = '{3, 17, 1'b0, 46, 0, 17, 185, 0, 0};
`else
    tbl[5] = '{1,  4, 1'b0,  4, 1,  2,  17, 0, 0};
    tbl[6] = '{3, 17, 1'b0, 15, 1, 17,  61, 0, 0};
`endif
    tbl[7] = '{0,  0, 1'b1,  0, 0,  0,   2, 0, 1};
    tbl[8] = '{2,  0, 1'b0,  0, 0,  0,   1, 0, 0};
`ifdef HPDMC_IDELAY_LIMIT_EN
    tbl[9] = '{2,  2, 1'b0,  0, 0,  0,   1, 1, 0};
`else
    tbl[9] = '{2,  2, 1'b0,  2, 0, 62,   9, 0, 0};
`endif

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = IDELAY_OP_RESET;
    cmd_if.cmd_arg   = '0;

    // Reset and release
    repeat (3) @(negedge sys_clk);
    chk("rst_hold_idelay_rst", int'(idelay_rst), 1);
    chk("rst_hold_tap", int'(cmd_if.tap), 0);
    chk("rst_hold_ready", int'(cmd_if.cmd_ready), 0);
    chk("rst_hold_ce", int'(idelay_ce), 0);
    chk("rst_hold_done", int'(cmd_if.done), 0);
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("release_c1_idelay_rst", int'(idelay_rst), 1);
    chk("release_c1_ready", int'(cmd_if.cmd_ready), 0);
    chk("release_c1_tap", int'(cmd_if.tap), 0);
    @(negedge sys_clk);
    chk("release_c2_idelay_rst", int'(idelay_rst), 0);
    chk("release_c2_ready", int'(cmd_if.cmd_ready), 1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].op, tbl[i].arg, tbl[i].hold, tbl[i].dir, p, bd, r, l, c, v, ra);
      chk($sformatf("tbl%0d_pulses", i), p, tbl[i].pulses);
      chk($sformatf("tbl%0d_inc_dir", i), bd, 0);
      chk($sformatf("tbl%0d_rst_pulses", i), r, tbl[i].rsts);
      chk($sformatf("tbl%0d_done_latency", i), l, tbl[i].lat);
      chk($sformatf("tbl%0d_clamped", i), c, tbl[i].clamped);
      chk($sformatf("tbl%0d_protocol", i), v, 0);
      chk($sformatf("tbl%0d_ready_after", i), ra, 1);
      chk($sformatf("tbl%0d_tap", i), int'(cmd_if.tap), tbl[i].tap);
    end
    m_tap = tbl[9].tap;

    // Random commands against the model
    for (int i = 0; i < 30; i++) begin
      int op, arg;
      op  = int'($urandom_range(0, 3));
      arg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TAPS - 1))
                                        : int'($urandom_range(0, 6));
      apply_model(op, arg, $sformatf("rnd%0d", i));
    end

    // Abort an INC 10 after its second pulse
    apply_model(3, 0, "pre_abort_set0");
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = IDELAY_OP_INC;
    cmd_if.cmd_arg   = TAP_W'(10);
    p = 0; dn = 0;
    for (int k = 0; k < 20 && p < 2; k++) begin
      @(negedge sys_clk);
      cmd_if.cmd_valid = 1'b0;
      if (idelay_ce) p++;
      if (cmd_if.done) dn++;
    end
    chk("abort_pulses_before_rst", p, 2);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("abort_tap", int'(cmd_if.tap), 0);
    chk("abort_ce", int'(idelay_ce), 0);
    chk("abort_idelay_rst", int'(idelay_rst), 1);
    if (cmd_if.done) dn++;
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("abort_release_idelay_rst", int'(idelay_rst), 1);
    chk("abort_release_ready", int'(cmd_if.cmd_ready), 0);
    if (cmd_if.done || idelay_ce) dn++;
    @(negedge sys_clk);
    chk("abort_ready", int'(cmd_if.cmd_ready), 1);
    chk("abort_idle_tap", int'(cmd_if.tap), 0);
    repeat (6) begin
      @(negedge sys_clk);
      if (cmd_if.done || idelay_ce) dn++;
    end
    chk("abort_no_done_or_ce", dn, 0);
    m_tap = 0;
    apply_model(1, 2, "post_abort_inc2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
